// File: rtl/id_ex_stage.sv
// RV32I decode stage: regfile read with write-through bypass, load-use hazard
// detection, and the ID/EX pipeline register feeding execute.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_pl_in,
  input  logic [31:0]     instr_pl_in,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard_stall,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_ex_out,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [XLEN-1:0] imm_out,
  output logic [4:0]      rd_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [2:0]      funct3_out,
  output logic [3:0]      alu_op_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            branch_out,
  output logic            jump_out,
  output logic            alu_src_imm_out,
  output logic            alu_src_pc_out,
  output logic            illegal_out
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic [3:0]      w_alu_op, w_alu_f3;
  logic            w_reg_write, w_mem_read, w_mem_write, w_branch, w_jump;
  logic            w_src_imm, w_src_pc, w_illegal, w_uses_rs1, w_uses_rs2;
  logic            w_bubble;

  logic [XLEN-1:0] r_rf [REG_COUNT];
  logic            r_valid, r_reg_write, r_mem_read, r_mem_write, r_branch, r_jump;
  logic            r_src_imm, r_src_pc, r_illegal;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [2:0]      r_funct3;
  logic [3:0]      r_alu_op;

  assign w_opcode = instr_pl_in[6:0];
  assign w_rd     = instr_pl_in[11:7];
  assign w_funct3 = instr_pl_in[14:12];
  assign w_rs1    = instr_pl_in[19:15];
  assign w_rs2    = instr_pl_in[24:20];

  assign w_imm_i = {{(XLEN-12){instr_pl_in[31]}}, instr_pl_in[31:20]};
  assign w_imm_s = {{(XLEN-12){instr_pl_in[31]}}, instr_pl_in[31:25], instr_pl_in[11:7]};
  assign w_imm_b = {{(XLEN-13){instr_pl_in[31]}}, instr_pl_in[31], instr_pl_in[7],
                    instr_pl_in[30:25], instr_pl_in[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){instr_pl_in[31]}}, instr_pl_in[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){instr_pl_in[31]}}, instr_pl_in[31], instr_pl_in[19:12],
                    instr_pl_in[20], instr_pl_in[30:21], 1'b0};

  // Writeback in the same cycle is forwarded so WB->ID needs no extra stall.
  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 :
                      (wb_en && wb_addr == w_rs1) ? wb_data : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 :
                      (wb_en && wb_addr == w_rs2) ? wb_data : r_rf[w_rs2];

  always_comb begin
    case (w_funct3)
      3'd0:    w_alu_f3 = (w_opcode == OP_REG && instr_pl_in[30]) ? ALU_SUB : ALU_ADD;
      3'd1:    w_alu_f3 = ALU_SLL;
      3'd2:    w_alu_f3 = ALU_SLT;
      3'd3:    w_alu_f3 = ALU_SLTU;
      3'd4:    w_alu_f3 = ALU_XOR;
      3'd5:    w_alu_f3 = instr_pl_in[30] ? ALU_SRA : ALU_SRL;
      3'd6:    w_alu_f3 = ALU_OR;
      default: w_alu_f3 = ALU_AND;
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD; w_imm = '0;
    w_reg_write = 1'b0; w_mem_read = 1'b0; w_mem_write = 1'b0; w_branch = 1'b0;
    w_jump = 1'b0; w_src_imm = 1'b0; w_src_pc = 1'b0; w_illegal = 1'b0;
    w_uses_rs1 = 1'b0; w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_LUI:   begin w_alu_op = ALU_PASSB; w_imm = w_imm_u; w_src_imm = 1'b1; w_reg_write = 1'b1; end
      OP_AUIPC: begin w_imm = w_imm_u; w_src_imm = 1'b1; w_src_pc = 1'b1; w_reg_write = 1'b1; end
      OP_JAL:   begin w_imm = w_imm_j; w_jump = 1'b1; w_reg_write = 1'b1; end
      OP_JALR:  begin w_imm = w_imm_i; w_src_imm = 1'b1; w_jump = 1'b1; w_reg_write = 1'b1;
                      w_uses_rs1 = 1'b1; end
      OP_BR:    begin w_imm = w_imm_b; w_alu_op = ALU_SUB; w_branch = 1'b1;
                      w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      OP_LD:    begin w_imm = w_imm_i; w_src_imm = 1'b1; w_mem_read = 1'b1; w_reg_write = 1'b1;
                      w_uses_rs1 = 1'b1; end
      OP_ST:    begin w_imm = w_imm_s; w_src_imm = 1'b1; w_mem_write = 1'b1;
                      w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      OP_IMM:   begin w_imm = w_imm_i; w_src_imm = 1'b1; w_alu_op = w_alu_f3; w_reg_write = 1'b1;
                      w_uses_rs1 = 1'b1; end
      OP_REG:   begin w_alu_op = w_alu_f3; w_reg_write = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      default:  w_illegal = 1'b1;
    endcase
  end

  assign hazard_stall = valid_in & r_valid & r_mem_read & (r_rd != 5'd0) &
                        ((w_uses_rs1 & (w_rs1 == r_rd)) | (w_uses_rs2 & (w_rs2 == r_rd)));

  // Folds reset > flush > stall > hazard/empty into one bubble condition.
  assign w_bubble = reset | flush | (~stall & (hazard_stall | ~valid_in));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid <= 1'b0; r_pc <= '0; r_rs1_data <= '0; r_rs2_data <= '0; r_imm <= '0;
      r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0; r_funct3 <= '0; r_alu_op <= '0;
      r_reg_write <= 1'b0; r_mem_read <= 1'b0; r_mem_write <= 1'b0; r_branch <= 1'b0;
      r_jump <= 1'b0; r_src_imm <= 1'b0; r_src_pc <= 1'b0; r_illegal <= 1'b0;
    end else if (!stall) begin
      r_valid <= 1'b1; r_pc <= pc_pl_in; r_rs1_data <= w_rs1_data; r_rs2_data <= w_rs2_data;
      r_imm <= w_imm; r_rd <= w_rd; r_rs1 <= w_rs1; r_rs2 <= w_rs2; r_funct3 <= w_funct3;
      r_alu_op <= w_alu_op; r_reg_write <= w_reg_write; r_mem_read <= w_mem_read;
      r_mem_write <= w_mem_write; r_branch <= w_branch; r_jump <= w_jump;
      r_src_imm <= w_src_imm; r_src_pc <= w_src_pc; r_illegal <= w_illegal;
    end
  end

  assign valid_out = r_valid;         assign pc_ex_out = r_pc;
  assign rs1_data_out = r_rs1_data;   assign rs2_data_out = r_rs2_data;
  assign imm_out = r_imm;             assign rd_out = r_rd;
  assign rs1_out = r_rs1;             assign rs2_out = r_rs2;
  assign funct3_out = r_funct3;       assign alu_op_out = r_alu_op;
  assign reg_write_out = r_reg_write; assign mem_read_out = r_mem_read;
  assign mem_write_out = r_mem_write; assign branch_out = r_branch;
  assign jump_out = r_jump;           assign alu_src_imm_out = r_src_imm;
  assign alu_src_pc_out = r_src_pc;   assign illegal_out = r_illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against an instruction-level model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset, valid_in, stall, flush, wb_en;
  logic [31:0] pc_pl_in, instr_pl_in, wb_data;
  logic [4:0]  wb_addr;
  logic        hazard_stall, valid_out;
  logic [31:0] pc_ex_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]  rd_out, rs1_out, rs2_out;
  logic [2:0]  funct3_out;
  logic [3:0]  alu_op_out;
  logic        reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out;
  logic        alu_src_imm_out, alu_src_pc_out, illegal_out;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .pc_pl_in(pc_pl_in), .instr_pl_in(instr_pl_in),
    .valid_in(valid_in), .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .hazard_stall(hazard_stall),
    .valid_out(valid_out), .pc_ex_out(pc_ex_out), .rs1_data_out(rs1_data_out),
    .rs2_data_out(rs2_data_out), .imm_out(imm_out), .rd_out(rd_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .funct3_out(funct3_out),
    .alu_op_out(alu_op_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .branch_out(branch_out), .jump_out(jump_out),
    .alu_src_imm_out(alu_src_imm_out), .alu_src_pc_out(alu_src_pc_out),
    .illegal_out(illegal_out));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [3:0]  alu;
    logic        rw, mr, mw, br, jp, simm, spc, ill;
  } idex_t;

  int vectors = 0, miscompares = 0;
  idex_t exp_st = '0;
  idex_t obs;
  logic [31:0] rf [32];
  logic [3:0] f3_alu [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h03};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] rd_rf(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return rf[idx];
  endfunction

  // Instruction-level meaning of one RV32I word as it should appear in ID/EX.
  function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
    idex_t e = '0;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_j;
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.valid = 1'b1; e.pc = pc; e.rs1d = a; e.rs2d = b;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.funct3 = ins[14:12];
    case (ins[6:0])
      7'h37: begin e.alu = 4'd10; e.imm = ins & 32'hFFFFF000; e.simm = 1; e.rw = 1; end
      7'h17: begin e.imm = ins & 32'hFFFFF000; e.simm = 1; e.spc = 1; e.rw = 1; end
      7'h6F: begin e.imm = imm_j; e.jp = 1; e.rw = 1; end
      7'h67: begin e.imm = imm_i; e.simm = 1; e.jp = 1; e.rw = 1; end
      7'h63: begin e.imm = imm_b; e.alu = 4'd1; e.br = 1; end
      7'h03: begin e.imm = imm_i; e.simm = 1; e.mr = 1; e.rw = 1; end
      7'h23: begin e.imm = imm_s; e.simm = 1; e.mw = 1; end
      7'h13, 7'h33: begin
        e.rw = 1;
        e.alu = f3_alu[ins[14:12]];
        if (ins[14:12] == 3'd5 && ins[30]) e.alu = 4'd7;
        if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[30]) e.alu = 4'd1;
        if (ins[6:0] == 7'h13) begin e.imm = imm_i; e.simm = 1; end
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic model_hazard();
    logic [6:0] op = instr_pl_in[6:0];
    logic u1 = op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic u2 = op inside {7'h63, 7'h23, 7'h33};
    return valid_in && exp_st.valid && exp_st.mr && exp_st.rd != 0 &&
           ((u1 && instr_pl_in[19:15] == exp_st.rd) || (u2 && instr_pl_in[24:20] == exp_st.rd));
  endfunction

  // One clock: check hazard on current inputs, advance the model, check ID/EX.
  task automatic step();
    logic eh;
    #1;
    eh = model_hazard();
    chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, eh});
    if (reset) begin
      exp_st = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
    end else begin
      if (flush) exp_st = '0;
      else if (!stall)
        exp_st = (eh || !valid_in) ? '0 :
                 model_decode(instr_pl_in, pc_pl_in, rd_rf(instr_pl_in[19:15]), rd_rf(instr_pl_in[24:20]));
      if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
    end
    @(posedge clk); #1;
    obs = {valid_out, pc_ex_out, rs1_data_out, rs2_data_out, imm_out, rd_out, rs1_out, rs2_out,
           funct3_out, alu_op_out, reg_write_out, mem_read_out, mem_write_out, branch_out,
           jump_out, alu_src_imm_out, alu_src_pc_out, illegal_out};
    vectors++;
    assert (obs === exp_st) else begin
      miscompares++;
      $error("FAIL idex_state observed=%h expected=%h", obs, exp_st);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    instr_pl_in = ins; pc_pl_in = pc; valid_in = v;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1; valid_in = 0; stall = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    pc_pl_in = 0; instr_pl_in = 0;
    repeat (3) step();
    reset = 0;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);

    drive(32'h00500093, 32'h100, 1); step();   // addi x1,x0,5
    chk("addi_valid", {31'd0, valid_out}, 32'd1);
    chk("addi_rd", {27'd0, rd_out}, 32'd1);
    chk("addi_imm", imm_out, 32'd5);
    chk("addi_alu", {28'd0, alu_op_out}, 32'd0);
    chk("addi_rw", {31'd0, reg_write_out}, 32'd1);
    chk("addi_simm", {31'd0, alu_src_imm_out}, 32'd1);
    chk("addi_rs1d", rs1_data_out, 32'd0);

    wb_en = 1; wb_addr = 1; wb_data = 32'hDEADBEEF;
    drive(32'h00108133, 32'h104, 1); step();   // add x2,x1,x1 with bypass
    chk("byp_rs1d", rs1_data_out, 32'hDEADBEEF);
    chk("byp_rs2d", rs2_data_out, 32'hDEADBEEF);
    wb_addr = 0; wb_data = 32'h12345678;
    drive(32'h000001B3, 32'h108, 1); step();   // add x3,x0,x0
    chk("x0_rs1d", rs1_data_out, 32'd0);
    wb_en = 0;

    drive(32'h00002283, 32'h10C, 1); step();   // lw x5,0(x0)
    drive(32'h00528333, 32'h110, 1); #1;       // add x6,x5,x5
    chk("lu_haz_on", {31'd0, hazard_stall}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, valid_out}, 32'd0);
    #1 chk("lu_haz_off", {31'd0, hazard_stall}, 32'd0);
    step();
    chk("lu_add_v", {31'd0, valid_out}, 32'd1);
    chk("lu_add_rs1", {27'd0, rs1_out}, 32'd5);
    chk("lu_add_rs2", {27'd0, rs2_out}, 32'd5);

    drive(32'hFE000CE3, 32'h114, 1); step();   // beq x0,x0,-8
    chk("beq_br", {31'd0, branch_out}, 32'd1);
    chk("beq_imm", imm_out, 32'hFFFFFFF8);
    chk("beq_alu", {28'd0, alu_op_out}, 32'd1);
    drive(32'hFFFFFFFF, 32'h118, 1); step();
    chk("ill_flag", {31'd0, illegal_out}, 32'd1);
    chk("ill_rw", {31'd0, reg_write_out}, 32'd0);

    drive(32'h00500093, 32'h200, 1); step();
    stall = 1;
    drive(32'hFE000CE3, 32'h204, 1); step();
    chk("stall1_imm", imm_out, 32'd5);
    chk("stall1_pc", pc_ex_out, 32'h200);
    drive(32'h00002283, 32'h208, 1); step();
    chk("stall2_rd", {27'd0, rd_out}, 32'd1);
    chk("stall2_pc", pc_ex_out, 32'h200);
    flush = 1; step();
    chk("sflush_v", {31'd0, valid_out}, 32'd0);
    chk("sflush_imm", imm_out, 32'd0);
    flush = 0; stall = 0;
    drive(32'h00500093, 32'h20C, 1); step();
    stall = 1; reset = 1; step();
    chk("srst_v", {31'd0, valid_out}, 32'd0);
    chk("srst_pc", pc_ex_out, 32'd0);
    stall = 0; reset = 0;
    drive(32'h00108133, 32'h210, 1); step();
    chk("rf_cleared", rs1_data_out, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins = $urandom;
      ins[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive(ins, $urandom, $urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 63) == 0);
      wb_en = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
